// File: rtl/mtimer_pkg.sv
// Shared constants and types for the RV64 machine timer block.
package mtimer_pkg;

    // Core data-bus width, reused as the timer register width.
    localparam int BUS_DATA_W = 64;

    // Default register offsets inside the timer region.
    localparam logic [15:0] DEF_OFS_MSIP     = 16'h0000;
    localparam logic [15:0] DEF_OFS_MTIMECMP = 16'h4000;
    localparam logic [15:0] DEF_OFS_MTIME    = 16'hBFF8;

    // mtimecmp starts at the maximum so no timer interrupt fires out of reset.
    localparam logic [BUS_DATA_W-1:0] MTIMECMP_RST = '1;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } bus_state_e;

    // Byte-lane merge: lanes with a set strobe take new_val, the rest keep old_val.
    function automatic logic [BUS_DATA_W-1:0] merge_bytes(
        input logic [BUS_DATA_W-1:0]   old_val,
        input logic [BUS_DATA_W-1:0]   new_val,
        input logic [BUS_DATA_W/8-1:0] strb
    );
        logic [BUS_DATA_W-1:0] res;
        for (int b = 0; b < BUS_DATA_W / 8; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Free-running clock divider; tick is high for one cycle every TICK_DIV cycles.
module mtimer_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // With TICK_DIV=1 the counter sits at 0 and tick stays high every cycle.
    assign tick = (cnt == LAST);

    // Count 0..TICK_DIV-1 and wrap on the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mtimer.sv
// RV64 machine timer: mtime / mtimecmp / msip behind a simple request/response bus.
module mtimer
    import mtimer_pkg::*;
#(
    parameter int                DATA_W       = BUS_DATA_W,
    parameter int                ADDR_W       = 16,
    parameter int                TICK_DIV     = 1,
    parameter logic [ADDR_W-1:0] OFS_MSIP     = ADDR_W'(DEF_OFS_MSIP),
    parameter logic [ADDR_W-1:0] OFS_MTIMECMP = ADDR_W'(DEF_OFS_MTIMECMP),
    parameter logic [ADDR_W-1:0] OFS_MTIME    = ADDR_W'(DEF_OFS_MTIME)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_wstrb_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                tmr_irq_o,
    output logic                sw_irq_o,
    output logic [DATA_W-1:0]   time_o
);

    bus_state_e        state, state_nxt;
    logic              accept;
    logic              aligned;
    logic              sel_msip, sel_cmp, sel_time;
    logic              addr_err;
    logic              wr;
    logic              tick;
    logic              msip;
    logic [DATA_W-1:0] mtime, mtime_nxt;
    logic [DATA_W-1:0] mtimecmp;
    logic [DATA_W-1:0] rd_data;

    mtimer_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Exact-match decode; any misaligned offset is an error even if it is inside a register.
    assign aligned  = (req_addr_i[2:0] == 3'b000);
    assign sel_msip = aligned && (req_addr_i == OFS_MSIP);
    assign sel_cmp  = aligned && (req_addr_i == OFS_MTIMECMP);
    assign sel_time = aligned && (req_addr_i == OFS_MTIME);
    assign addr_err = !(sel_msip || sel_cmp || sel_time);

    assign accept = req_valid_i && req_ready_o;
    assign wr     = accept && req_we_i && !addr_err;

    // Bus FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus FSM next state and handshake outputs: one access, then one response cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_nxt   = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read mux over the pre-edge register values.
    always_comb begin
        rd_data = '0;
        if (sel_msip) begin
            rd_data[0] = msip;
        end else if (sel_cmp) begin
            rd_data = mtimecmp;
        end else if (sel_time) begin
            rd_data = mtime;
        end
    end

    // Next mtime: increment on tick, then written byte lanes override the incremented value.
    always_comb begin
        mtime_nxt = mtime + DATA_W'(tick);
        if (wr && sel_time) begin
            mtime_nxt = merge_bytes(mtime_nxt, req_wdata_i, req_wstrb_i);
        end
    end

    // Timer registers, software-interrupt bit and the registered compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime     <= '0;
            mtimecmp  <= MTIMECMP_RST;
            msip      <= 1'b0;
            tmr_irq_o <= 1'b0;
        end else begin
            mtime     <= mtime_nxt;
            tmr_irq_o <= (mtime >= mtimecmp);
            if (wr && sel_cmp) begin
                mtimecmp <= merge_bytes(mtimecmp, req_wdata_i, req_wstrb_i);
            end
            if (wr && sel_msip && req_wstrb_i[0]) begin
                msip <= req_wdata_i[0];
            end
        end
    end

    // Response payload captured at acceptance; zero whenever no response is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_err_o   <= accept && addr_err;
            rsp_rdata_o <= (accept && !req_we_i) ? rd_data : '0;
        end
    end

    assign sw_irq_o = msip;
    assign time_o   = mtime;

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: two instances (TICK_DIV=1 and 4) on a shared bus,
// a cycle-level reference model, directed sequences and a vector table.
module tb_mtimer;

    localparam logic [15:0] A_MSIP = 16'h0000;
    localparam logic [15:0] A_CMP  = 16'h4000;
    localparam logic [15:0] A_TIME = 16'hBFF8;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;

    logic        rdy  [2];
    logic        rvld [2];
    logic [63:0] rdat [2];
    logic        rerr [2];
    logic        tirq [2];
    logic        sirq [2];
    logic [63:0] tim  [2];

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    mtimer #(.TICK_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(rdy[0]), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rvld[0]), .rsp_rdata_o(rdat[0]), .rsp_err_o(rerr[0]),
        .tmr_irq_o(tirq[0]), .sw_irq_o(sirq[0]), .time_o(tim[0])
    );

    mtimer #(.TICK_DIV(4)) dut_div4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(rdy[1]), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rvld[1]), .rsp_rdata_o(rdat[1]), .rsp_err_o(rerr[1]),
        .tmr_irq_o(tirq[1]), .sw_irq_o(sirq[1]), .time_o(tim[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [63:0] lane_write(input logic [63:0] old_v, input logic [63:0] new_v,
                                               input logic [7:0] strb);
        logic [63:0] mask = '0;
        for (int b = 0; b < 8; b++) if (strb[b]) mask |= (64'hFF << (8 * b));
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    longint unsigned m_cyc;
    logic [63:0]     m_time  [2];
    logic [63:0]     m_cmp   [2];
    logic [63:0]     m_rdata [2];
    logic            m_msip  [2];
    logic            m_irq   [2];
    logic            m_err   [2];
    logic            m_busy;
    logic            m_acc, m_bad, m_hmsip, m_hcmp, m_htime;
    logic [63:0]     m_rd, m_nt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc  = 0;
            m_busy = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_time[i] = '0; m_cmp[i] = ONES; m_msip[i] = 1'b0;
                m_irq[i] = 1'b0; m_rdata[i] = '0; m_err[i] = 1'b0;
            end
        end else begin
            m_acc   = req_valid && !m_busy;
            m_hmsip = (req_addr == A_MSIP);
            m_hcmp  = (req_addr == A_CMP);
            m_htime = (req_addr == A_TIME);
            m_bad   = (req_addr[2:0] != 3'b000) || !(m_hmsip || m_hcmp || m_htime);
            for (int i = 0; i < 2; i++) begin
                m_irq[i] = (m_time[i] >= m_cmp[i]);
                m_rd = '0;
                if (m_acc && !m_bad && !req_we)
                    m_rd = m_hmsip ? {63'b0, m_msip[i]} : (m_hcmp ? m_cmp[i] : m_time[i]);
                m_nt = m_time[i] + (((m_cyc + 1) % div_of(i) == 0) ? 64'd1 : 64'd0);
                if (m_acc && req_we && !m_bad) begin
                    if (m_htime) m_nt = lane_write(m_nt, req_wdata, req_wstrb);
                    if (m_hcmp) m_cmp[i] = lane_write(m_cmp[i], req_wdata, req_wstrb);
                    if (m_hmsip && req_wstrb[0]) m_msip[i] = req_wdata[0];
                end
                m_time[i]  = m_nt;
                m_rdata[i] = m_rd;
                m_err[i]   = m_acc && m_bad;
            end
            m_busy = m_acc;
            m_cyc++;
        end
    end

    // Every cycle, both instances are compared against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d.time", i), tim[i], m_time[i]);
                check($sformatf("u%0d.tmr_irq", i), tirq[i], m_irq[i]);
                check($sformatf("u%0d.sw_irq", i), sirq[i], m_msip[i]);
                check($sformatf("u%0d.rsp_valid", i), rvld[i], m_busy);
                check($sformatf("u%0d.req_ready", i), rdy[i], !m_busy);
                check($sformatf("u%0d.rsp_rdata", i), rdat[i], m_rdata[i]);
                check($sformatf("u%0d.rsp_err", i), rerr[i], m_err[i]);
            end
        end
    end

    // One bus access; returns at the falling edge of the response cycle.
    task automatic access(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wstrb);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait until the next bus acceptance would land on a prescaler tick of the div-4 instance.
    task automatic align_tick4(input string name);
        int k = 0;
        while ((m_cyc % 4) != 2 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check(name, m_cyc % 4, 64'd2);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        exp_err;
        logic [63:0] exp_rdata;
        logic        exp_sw;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, A_MSIP,  ONES,                   8'hFF, 1'b0, 64'h0, 1'b1};
        vecs[1]  = '{1'b0, A_MSIP,  64'h0,                  8'hFF, 1'b0, 64'h1, 1'b1};
        vecs[2]  = '{1'b1, 16'h4004, ONES,                  8'hFF, 1'b1, 64'h0, 1'b1};
        vecs[3]  = '{1'b0, 16'h0010, 64'h0,                 8'hFF, 1'b1, 64'h0, 1'b1};
        vecs[4]  = '{1'b1, A_MSIP,  64'h0,                  8'hFF, 1'b0, 64'h0, 1'b0};
        vecs[5]  = '{1'b0, A_MSIP,  64'h0,                  8'hFF, 1'b0, 64'h0, 1'b0};
        vecs[6]  = '{1'b1, A_CMP,   64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b0, 64'h0, 1'b0};
        vecs[7]  = '{1'b1, A_CMP,   ONES,                   8'h0F, 1'b0, 64'h0, 1'b0};
        vecs[8]  = '{1'b0, A_CMP,   64'h0,                  8'hFF, 1'b0, 64'h1234_5678_FFFF_FFFF, 1'b0};
        vecs[9]  = '{1'b1, 16'h4004, 64'h0,                 8'hFF, 1'b1, 64'h0, 1'b0};
        vecs[10] = '{1'b0, A_CMP,   64'h0,                  8'hFF, 1'b0, 64'h1234_5678_FFFF_FFFF, 1'b0};
        vecs[11] = '{1'b0, 16'h4001, 64'h0,                 8'hFF, 1'b1, 64'h0, 1'b0};
        vecs[12] = '{1'b1, 16'hBFFC, ONES,                  8'hFF, 1'b1, 64'h0, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(negedge clk);

        // Reset values before the first counting edge.
        check("rst.time", tim[0], 64'h0);
        check("rst.tmr_irq", tirq[0], 64'h0);
        check("rst.sw_irq", sirq[0], 64'h0);
        check("rst.rsp_valid", rvld[0], 64'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst.req_ready", rdy[0], 64'h1);

        // Ten idle cycles at TICK_DIV=1, then read mtime.
        repeat (10) @(posedge clk);
        #1;
        check("idle10.time", tim[0], 64'd10);
        check("idle10.tmr_irq", tirq[0], 64'h0);
        access(1'b0, A_TIME, '0, 8'hFF);
        check("rd_mtime.rsp_valid", rvld[0], 64'h1);
        check("rd_mtime.rdata", rdat[0], 64'd10);
        check("rd_mtime.err", rerr[0], 64'h0);
        @(negedge clk);
        check("rd_mtime.rsp_one_cycle", rvld[0], 64'h0);
        check("rd_mtime.rdata_cleared", rdat[0], 64'h0);

        // Timer interrupt rises one cycle after mtime reaches mtimecmp, drops after a raise.
        access(1'b1, A_CMP, 64'd20, 8'hFF);
        for (int k = 0; k < 100 && tim[0] != 64'd20; k++) @(negedge clk);
        check("cmp20.reach", tim[0], 64'd20);
        check("cmp20.irq_lag", tirq[0], 64'h0);
        @(negedge clk);
        check("cmp20.irq_rise", tirq[0], 64'h1);
        access(1'b1, A_CMP, 64'd1000, 8'hFF);
        check("cmp1000.irq_at_acc", tirq[0], 64'h1);
        @(negedge clk);
        check("cmp1000.irq_clear", tirq[0], 64'h0);

        // Vector table: msip, mtimecmp byte lanes and error accesses.
        for (int v = 0; v < 13; v++) begin
            access(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
            check($sformatf("vec%0d.err", v), rerr[0], vecs[v].exp_err);
            check($sformatf("vec%0d.rdata", v), rdat[0], vecs[v].exp_rdata);
            check($sformatf("vec%0d.sw_irq", v), sirq[0], vecs[v].exp_sw);
        end

        // Byte-strobe mtime write on a tick of the div-4 instance.
        align_tick4("align_a");
        access(1'b1, A_TIME, 64'h0, 8'hFF);
        check("div4.zero", tim[1], 64'h0);
        align_tick4("align_b");
        check("div4.pre", tim[1], 64'h0);
        access(1'b1, A_TIME, 64'hAABB, 8'h01);
        check("div4.merge", tim[1], 64'hBB);
        repeat (3) @(negedge clk);
        check("div4.hold", tim[1], 64'hBB);
        @(negedge clk);
        check("div4.next_tick", tim[1], 64'hBC);

        // mtime wrap with mtimecmp = 0x12345678_FFFFFFFF.
        access(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
        check("wrap.fe", tim[0], 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        check("wrap.ff", tim[0], ONES);
        check("wrap.irq_hi", tirq[0], 64'h1);
        @(negedge clk);
        check("wrap.zero", tim[0], 64'h0);
        check("wrap.irq_still", tirq[0], 64'h1);
        @(negedge clk);
        check("wrap.irq_low", tirq[0], 64'h0);

        // Randomised accesses against the model.
        for (int n = 0; n < 150; n++) begin
            logic [15:0] a;
            case ($urandom_range(0, 5))
                0:       a = A_MSIP;
                1:       a = A_CMP;
                2, 3:    a = A_TIME;
                4:       a = 16'($urandom) & 16'hFFF8;
                default: a = (16'($urandom) & 16'hFFF8) | 16'($urandom_range(1, 7));
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            access(1'($urandom), a, {$urandom, $urandom}, 8'($urandom));
        end

        // Reset during the response cycle.
        access(1'b1, A_MSIP, 64'h1, 8'hFF);
        access(1'b1, A_CMP, 64'h0, 8'hFF);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = A_CMP; req_wstrb = 8'hFF;
        @(posedge clk);
        #1;
        check("midrst.in_resp", rvld[0], 64'h1);
        rst_n = 1'b0;
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("midrst.u%0d.rsp_valid", i), rvld[i], 64'h0);
            check($sformatf("midrst.u%0d.rdata", i), rdat[i], 64'h0);
            check($sformatf("midrst.u%0d.time", i), tim[i], 64'h0);
            check($sformatf("midrst.u%0d.tmr_irq", i), tirq[i], 64'h0);
            check($sformatf("midrst.u%0d.sw_irq", i), sirq[i], 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, A_CMP, '0, 8'hFF);
        check("midrst.cmp_reset", rdat[0], ONES);
        access(1'b0, A_MSIP, '0, 8'hFF);
        check("midrst.msip_reset", rdat[0], 64'h0);
        @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mtimer.md
Name: mtimer

Overview:
- Memory-mapped RV64 machine timer and software-interrupt unit.
- Holds mtime, mtimecmp and msip.
- Produces the timer interrupt that the interrupt controller samples on its tmr_irq_i input, plus a software interrupt line.
- Sits on the core's peripheral data bus, beside the CSR/interrupt logic. Provides a free-running time value for the time CSR.

Parameters:
- DATA_W, 64, bus data width; fixed 64 for RV64.
- ADDR_W, 16, byte-offset width inside the timer region.
- TICK_DIV, 1, clk cycles per mtime increment; legal range >= 1.
- OFS_MSIP, 16'h0000, msip register offset.
- OFS_MTIMECMP, 16'h4000, mtimecmp register offset.
- OFS_MTIME, 16'hBFF8, mtime register offset.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset: asynchronous, active-low
- req_valid_i  in  1  bus request valid
- req_ready_o  out  1  block can accept a request
- req_we_i  in  1  1=write, 0=read
- req_addr_i  in  ADDR_W  byte offset
- req_wdata_i  in  DATA_W  write data
- req_wstrb_i  in  DATA_W/8  byte write strobes
- rsp_valid_o  out  1  response pulse
- rsp_rdata_o  out  DATA_W  read data
- rsp_err_o  out  1  access error
- tmr_irq_o  out  1  machine timer interrupt, to interrupt controller
- sw_irq_o  out  1  machine software interrupt
- time_o  out  DATA_W  current mtime, for the time CSR

Behaviour:
- Reset values (all asynchronous on rst_n low):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0.
  - State IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, tmr_irq_o=0, sw_irq_o=0.
  - req_ready_o=1 immediately after reset release.
- Bus FSM, states IDLE and RESP:
  - IDLE: req_ready_o=1. A request is accepted when req_valid_i & req_ready_o at a rising edge. The write is committed at that edge, read data is captured at that edge, and the state moves to RESP.
  - RESP: rsp_valid_o=1 for exactly one cycle, req_ready_o=0, then back to IDLE.
  - No response back-pressure. Throughput is one access per 2 cycles; read latency is 1 cycle after acceptance.
- Address decode (exact match on req_addr_i):
  - OFS_MSIP: bit0 only is writable, reads {63'b0,msip}.
  - OFS_MTIMECMP and OFS_MTIME: full 64-bit, byte-lane writes per req_wstrb_i.
  - Any other offset, or req_addr_i[2:0]!=0: rsp_err_o=1, rsp_rdata_o=0, no state change.
  - rsp_err_o and rsp_rdata_o are held valid only while rsp_valid_o=1 and are 0 otherwise.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - mtime increments by 1 on the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - With TICK_DIV=1, mtime increments every cycle.
- mtime wrap: 64'hFFFF_FFFF_FFFF_FFFF increments to 0 with no flag.
- Write to mtime in the same cycle as a tick:
  - The written bytes take the written value; unwritten bytes take the incremented value.
  - The prescaler is not reset by an mtime write.
- Interrupt outputs:
  - tmr_irq_o is registered: tmr_irq_o <= (mtime >= mtimecmp), an unsigned compare of the current register values. The output therefore lags a register change by 1 cycle.
  - tmr_irq_o is level, not sticky: it clears 1 cycle after a mtimecmp write raises the compare above mtime.
  - sw_irq_o = msip register (registered, directly driven).
- time_o = mtime register, no extra delay.
- Reset asserted mid-access: the FSM returns to IDLE, any pending response is dropped, and all registers take their reset values.
- req_valid_i while in RESP is ignored. The master must hold the request until it is accepted.

Decomposition:
- Shared defines: the three offsets, a MTIMECMP_RST constant, and DATA_W reuse of the existing data-bus width define.
- One natural sub-module, mtimer_prescaler: counter plus tick pulse output, parameter TICK_DIV.
- Bus FSM, registers and compare stay in the top module.

Test Plan:
- Reset release, TICK_DIV=1, no accesses for 10 cycles:
  - time_o=10, tmr_irq_o=0.
  - A read at 16'hBFF8 returns the value of mtime at acceptance, with rsp_valid_o exactly 1 cycle later.
- Write mtimecmp=64'd20 with wstrb=8'hFF, TICK_DIV=1:
  - tmr_irq_o rises the cycle after mtime reaches 20.
  - A subsequent write mtimecmp=64'd1000 drops tmr_irq_o 1 cycle after acceptance.
- Write msip with wdata=64'hFFFF_FFFF_FFFF_FFFF:
  - sw_irq_o=1; a read of OFS_MSIP returns 64'h1.
  - Writing 0 clears sw_irq_o on the next cycle.
- Byte-strobe write, mtime=64'h0 with TICK_DIV=4, write wdata=64'hAABB with wstrb=8'h01 coincident with a tick:
  - mtime becomes 64'h00BB (byte0 from the write, other bytes from the increment, i.e. still 0).
- Error cases, each producing rsp_err_o=1 and rsp_rdata_o=0 with no register change:
  - Read at offset 16'h0010 (unmapped).
  - Write at 16'h4004 (misaligned).
- Wrap and reset:
  - Write mtime=64'hFFFF_FFFF_FFFF_FFFE with TICK_DIV=1: mtime reaches 0 two cycles later and tmr_irq_o stays consistent with the compare.
  - Assert rst_n low while in RESP: rsp_valid_o=0 immediately and all registers return to their reset values.
